// File: rtl/mtx_arbiter_pkg.sv
// mtx_arbiter_pkg
//   Shared helper for the MIO transmit arbiter slice.
//   oh_to_idx : encodes a one-hot vector of up to 8 bits to its bit index
//               (returns 0 for an all-zero vector).
package mtx_arbiter_pkg;

  function automatic int unsigned oh_to_idx(input logic [7:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 8; i++)
      if (oh[i]) idx = i;
    return idx;
  endfunction

endpackage

// File: rtl/mtx_rr_arbiter.sv
// mtx_rr_arbiter
//   Combinational rotate / find-first / rotate-back arbiter.
//   Ports:
//     req   in  NREQ   request vector
//     ptr   in  log2   last round-robin winner; the search starts at ptr+1
//     fixed in  1      1 = fixed priority, index 0 highest (ptr ignored)
//     grant out NREQ   one-hot winner, zero when no request
module mtx_rr_arbiter #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  input  logic                    fixed,
  output logic [NREQ-1:0]         grant
);

  localparam int PTRW = $clog2(NREQ);

  logic [PTRW-1:0]   start;
  logic [2*NREQ-1:0] req_dbl;
  logic [2*NREQ-1:0] gnt_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [NREQ-1:0]   gnt_rot;

  always_comb begin
    if (fixed)
      start = '0;
    else if (ptr == PTRW'(NREQ - 1))
      start = '0;
    else
      start = ptr + PTRW'(1);
    // Rotate so the starting requester lands on bit 0.
    req_dbl = {req, req} >> start;
    req_rot = req_dbl[NREQ-1:0];
    // Isolate lowest set bit.
    gnt_rot = req_rot & (~req_rot + {{(NREQ-1){1'b0}}, 1'b1});
    // Rotate back into requester numbering.
    gnt_dbl = {gnt_rot, gnt_rot} << start;
    grant   = gnt_dbl[2*NREQ-1:NREQ];
  end

endmodule

// File: rtl/mtx_arbiter.sv
// mtx_arbiter
//   Packet arbiter/sequencer in front of the MIO transmit FIFO. One packet
//   per accept, round-robin or fixed priority, lockable multi-packet
//   sequences, registered output stage honouring FIFO pushback.
//   Ports:
//     clk, reset        core clock, synchronous active-high reset
//     tx_en             low blocks new grants (output stage still drains)
//     cfg_priority      1 = fixed priority, 0 = round-robin
//     access_in/lock_in per-requester valid / lock request
//     packet_in         requester i at [i*PW +: PW]
//     wait_out          per-requester pushback (combinational)
//     access_out/packet_out  output stage to the transmit FIFO
//     wait_in           FIFO pushback
//     grant_out         one-hot source of the packet in the output stage
//     locked_out        lock currently held
module mtx_arbiter
  import mtx_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int PW   = 136
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_en,
  input  logic               cfg_priority,
  input  logic [NREQ-1:0]    access_in,
  input  logic [NREQ-1:0]    lock_in,
  input  logic [NREQ*PW-1:0] packet_in,
  output logic [NREQ-1:0]    wait_out,
  output logic               access_out,
  output logic [PW-1:0]      packet_out,
  input  logic               wait_in,
  output logic [NREQ-1:0]    grant_out,
  output logic               locked_out
);

  localparam int PTRW = $clog2(NREQ);

  logic [PTRW-1:0] rr_ptr;
  logic [PTRW-1:0] owner;
  logic            locked;

  logic [NREQ-1:0] owner_oh;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] winner;
  logic [NREQ-1:0] accept;
  logic            load_en;
  logic [PTRW-1:0] win_idx;
  logic [PW-1:0]   win_pkt;
  logic            win_lock;

  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
  end

  // While locked only the owner may compete.
  assign elig = !tx_en ? '0 : (locked ? (access_in & owner_oh) : access_in);

  mtx_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (elig),
    .ptr   (rr_ptr),
    .fixed (cfg_priority),
    .grant (winner)
  );

  // Stage can take a new packet when empty or when the FIFO consumes it
  // this cycle, so release of wait_in refills without a bubble.
  assign load_en  = ~access_out | ~wait_in;
  assign accept   = load_en ? winner : '0;
  assign wait_out = reset ? '1 : ~accept;

  assign win_idx  = PTRW'(oh_to_idx(8'(winner)));
  assign win_pkt  = packet_in[win_idx*PW +: PW];
  assign win_lock = lock_in[win_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      access_out <= 1'b0;
      packet_out <= '0;
      grant_out  <= '0;
      locked     <= 1'b0;
      owner      <= '0;
      rr_ptr     <= PTRW'(NREQ - 1);
    end else begin
      if (load_en) begin
        access_out <= |winner;
        grant_out  <= winner;
        if (|winner) packet_out <= win_pkt;
      end
      if (|accept) begin
        if (locked) begin
          if (!win_lock) locked <= 1'b0;
        end else if (win_lock) begin
          locked <= 1'b1;
          owner  <= win_idx;
        end
        // Pointer frozen for the body of a locked sequence; the releasing
        // packet (winner == owner) moves it so the search resumes at owner+1.
        if (!cfg_priority && (!locked || !win_lock))
          rr_ptr <= win_idx;
      end
    end
  end

  assign locked_out = locked;

endmodule

// File: tb/tb_mtx_arbiter.sv
module tb_mtx_arbiter;
  localparam int NREQ = 3;
  localparam int PW   = 136;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               tx_en = 1'b0;
  logic               cfg_priority = 1'b0;
  logic               wait_in = 1'b0;
  logic [NREQ-1:0]    access_in = '0;
  logic [NREQ-1:0]    lock_in = '0;
  logic [NREQ*PW-1:0] packet_in = '0;
  logic [NREQ-1:0]    wait_out;
  logic               access_out;
  logic [PW-1:0]      packet_out;
  logic [NREQ-1:0]    grant_out;
  logic               locked_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mtx_arbiter #(.NREQ(NREQ), .PW(PW)) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_en        (tx_en),
    .cfg_priority (cfg_priority),
    .access_in    (access_in),
    .lock_in      (lock_in),
    .packet_in    (packet_in),
    .wait_out     (wait_out),
    .access_out   (access_out),
    .packet_out   (packet_out),
    .wait_in      (wait_in),
    .grant_out    (grant_out),
    .locked_out   (locked_out)
  );

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pkt(input int i, input logic [PW-1:0] v);
    packet_in[i*PW +: PW] = v;
  endtask

  // Reference model: plain integer pointer/owner, priority search by index.
  bit              m_armed = 0;
  bit              m_av;
  logic [NREQ-1:0] m_gnt;
  logic [PW-1:0]   m_pkt;
  bit              m_locked;
  int              m_owner;
  int              m_ptr;

  always @(negedge clk) begin : model
    int win;
    int idx;
    bit load;
    logic [NREQ-1:0] exp_w;
    if (m_armed) begin
      chk("m_access_out", PW'(access_out), PW'(m_av));
      chk("m_grant_out", PW'(grant_out), PW'(m_av ? m_gnt : '0));
      if (m_av) chk("m_packet_out", packet_out, m_pkt);
      chk("m_locked_out", PW'(locked_out), PW'(m_locked));
    end
    if (reset) begin
      chk("m_wait_out_rst", PW'(wait_out), PW'({NREQ{1'b1}}));
      m_av = 0; m_gnt = '0; m_pkt = '0; m_locked = 0; m_owner = 0;
      m_ptr = NREQ - 1;
      m_armed = 1;
    end else if (m_armed) begin
      load = !m_av || !wait_in;
      win = -1;
      if (tx_en)
        for (int k = 0; k < NREQ; k++) begin
          idx = cfg_priority ? k : (m_ptr + 1 + k) % NREQ;
          if (win < 0 && access_in[idx] && (!m_locked || idx == m_owner)) win = idx;
        end
      exp_w = '1;
      if (load && win >= 0) exp_w[win] = 1'b0;
      chk("m_wait_out", PW'(wait_out), PW'(exp_w));
      if (load) begin
        m_av = (win >= 0);
        m_gnt = '0;
        if (win >= 0) begin
          m_gnt[win] = 1'b1;
          m_pkt = packet_in[win*PW +: PW];
        end
      end
      if (load && win >= 0) begin
        if (m_locked) begin
          if (!lock_in[win]) begin
            m_locked = 0;
            if (!cfg_priority) m_ptr = m_owner;
          end
        end else begin
          if (lock_in[win]) begin
            m_locked = 1;
            m_owner = win;
          end
          if (!cfg_priority) m_ptr = win;
        end
      end
    end
  end

  // Table-driven stretch: {tx_en, cfg_priority, wait_in, lock_in, access_in}
  logic [8:0] tbl [16] = '{
    9'b1_0_0_000_111, 9'b1_0_1_000_111, 9'b1_0_0_010_011, 9'b1_0_0_010_111,
    9'b1_0_1_010_101, 9'b1_0_0_000_110, 9'b1_1_0_000_111, 9'b1_1_0_001_001,
    9'b0_1_0_000_111, 9'b1_0_0_000_100, 9'b1_0_0_000_000, 9'b1_0_1_000_111,
    9'b1_1_0_100_110, 9'b1_0_0_000_011, 9'b1_0_0_000_111, 9'b1_0_0_000_000
  };

  initial begin
    for (int i = 0; i < NREQ; i++) set_pkt(i, PW'(32'h100 + i));

    // Reset state
    step(); step();
    chk("rst_access_out", PW'(access_out), PW'(1'b0));
    chk("rst_grant_out", PW'(grant_out), PW'(3'b000));
    chk("rst_locked_out", PW'(locked_out), PW'(1'b0));
    chk("rst_packet_out", packet_out, '0);
    chk("rst_wait_out", PW'(wait_out), PW'(3'b111));

    // Round-robin, all valid
    reset = 0; tx_en = 1; access_in = 3'b111;
    step(); chk("rr_g1", PW'(grant_out), PW'(3'b001)); chk("rr_av1", PW'(access_out), PW'(1'b1));
    step(); chk("rr_g2", PW'(grant_out), PW'(3'b010));
    step(); chk("rr_g3", PW'(grant_out), PW'(3'b100));
    step(); chk("rr_g4", PW'(grant_out), PW'(3'b001)); chk("rr_av4", PW'(access_out), PW'(1'b1));

    // Fixed priority, requesters 1 and 2
    cfg_priority = 1; access_in = 3'b110;
    #2 chk("fp_wait", PW'(wait_out), PW'(3'b101));
    step(); chk("fp_g1", PW'(grant_out), PW'(3'b010));
    step(); chk("fp_g2", PW'(grant_out), PW'(3'b010)); chk("fp_w2", PW'(wait_out[2]), PW'(1'b1));
    access_in = 3'b100;
    step(); chk("fp_g3", PW'(grant_out), PW'(3'b100));

    // Wait hold with 0xA5 from requester 0
    cfg_priority = 0; access_in = 3'b001; set_pkt(0, PW'(8'hA5));
    step(); chk("wt_load", packet_out, PW'(8'hA5));
    wait_in = 1; access_in = 3'b111;
    set_pkt(0, PW'(8'h11)); set_pkt(1, PW'(8'h22)); set_pkt(2, PW'(8'h33));
    repeat (5) begin
      #2;
      chk("wt_pkt", packet_out, PW'(8'hA5));
      chk("wt_wait", PW'(wait_out), PW'(3'b111));
      chk("wt_av", PW'(access_out), PW'(1'b1));
      step();
    end
    wait_in = 0;
    #2 chk("wt_rel_wait", PW'(wait_out), PW'(3'b101));
    step(); chk("wt_rel_pkt", packet_out, PW'(8'h22)); chk("wt_rel_g", PW'(grant_out), PW'(3'b010));

    // Lock sequence from requester 2
    lock_in = 3'b100;
    #2 chk("lk_wait0", PW'(wait_out), PW'(3'b011));
    step(); chk("lk_g1", PW'(grant_out), PW'(3'b100)); chk("lk_l1", PW'(locked_out), PW'(1'b1));
    #2 chk("lk_wait1", PW'(wait_out), PW'(3'b011));
    step(); chk("lk_g2", PW'(grant_out), PW'(3'b100)); chk("lk_l2", PW'(locked_out), PW'(1'b1));
    lock_in = 3'b000;
    step(); chk("lk_g3", PW'(grant_out), PW'(3'b100)); chk("lk_l3", PW'(locked_out), PW'(1'b0));
    step(); chk("lk_g4", PW'(grant_out), PW'(3'b001));

    // tx_en low mid-stream with the stage held
    tx_en = 0; wait_in = 1;
    #2 chk("tx_wait", PW'(wait_out), PW'(3'b111));
    step(); chk("tx_hold_av", PW'(access_out), PW'(1'b1)); chk("tx_hold_g", PW'(grant_out), PW'(3'b001));
    step();
    wait_in = 0;
    #2 chk("tx_wait2", PW'(wait_out), PW'(3'b111));
    step(); chk("tx_drain", PW'(access_out), PW'(1'b0));
    tx_en = 1;
    step(); chk("tx_resume", PW'(grant_out), PW'(3'b010)); chk("tx_resume_av", PW'(access_out), PW'(1'b1));

    // Reset with the lock held
    lock_in = 3'b100;
    step(); chk("rl_g", PW'(grant_out), PW'(3'b100)); chk("rl_l", PW'(locked_out), PW'(1'b1));
    reset = 1; lock_in = 3'b000;
    #2 chk("rl_wait", PW'(wait_out), PW'(3'b111));
    step(); chk("rl_av", PW'(access_out), PW'(1'b0)); chk("rl_lk", PW'(locked_out), PW'(1'b0));
    reset = 0;
    step(); chk("rl_first", PW'(grant_out), PW'(3'b001));

    // Mixed directed vectors checked by the model only
    for (int i = 0; i < 16; i++) begin
      {tx_en, cfg_priority, wait_in, lock_in, access_in} = tbl[i];
      for (int r = 0; r < NREQ; r++) set_pkt(r, PW'(32'h1000 * (r + 1) + i));
      step();
    end
    access_in = '0; lock_in = '0; wait_in = 0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mtx_arbiter.md
# mtx_arbiter

Packet arbiter and sequencer in front of the MIO transmit FIFO. It shares the single transmit FIFO input among NREQ emesh requesters, such as the write, read-request and read-response channels. It grants one packet per accepted transfer using round-robin or fixed priority, supports locked multi-packet sequences, and holds the winner in a registered output stage that obeys the FIFO's wait pushback. It sits on the core clock domain directly upstream of the transmit FIFO input.

## Interface
- NREQ, 3, number of requesters (2..8)
- PW, 136, packet width
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- tx_en  in  1  transmit enable; low blocks new grants
- cfg_priority  in  1  1 = fixed priority (index 0 highest), 0 = round-robin
- access_in  in  NREQ  per-requester packet valid
- lock_in  in  NREQ  per-requester lock request, sampled with an accepted packet
- packet_in  in  NREQ*PW  requester packets; requester i occupies bits [i*PW +: PW]
- wait_out  out  NREQ  per-requester pushback
- access_out  out  1  packet valid to transmit FIFO
- packet_out  out  PW  packet to transmit FIFO
- wait_in  in  1  pushback from transmit FIFO (half-full or emesh stall)
- grant_out  out  NREQ  one-hot, registered index of the requester whose packet is in the output stage (status)
- locked_out  out  1  lock currently held

## Operation
- Output stage: a single register holding access_out, packet_out and grant_out.
  - load_en = ~access_out | ~wait_in.
  - When load_en is high, the stage loads the arbitration winner. If there is no winner, access_out becomes 0.
  - When wait_in is high and access_out is high, the stage holds all of its values.
- Eligibility: requester i is eligible when access_in[i] is high and tx_en is high.
  - While a lock is held, only the lock owner is eligible.
- Winner selection:
  - cfg_priority=1: lowest eligible index wins.
  - cfg_priority=0: search starts at rr_ptr+1 mod NREQ.
- Acceptance: requester i is accepted when it is the winner and load_en is high.
  - wait_out[i] = ~(winner[i] & load_en).
  - wait_out[i] is combinational from wait_in, access_in, lock state and tx_en.
- rr_ptr update: on each accept, rr_ptr <= winner index.
  - rr_ptr does not update in fixed-priority mode.
  - rr_ptr does not update while a lock is held.
- Lock handling:
  - An accepted packet with lock_in[i]=1 sets the lock with owner = i.
  - An accepted packet from the owner with lock_in=0 clears the lock, and rr_ptr <= owner.
  - An idle owner keeps the lock; others stay blocked.
  - tx_en low does not clear the lock.
- tx_en low: no accepts occur and all wait_out bits are high. The output stage drains normally.
- cfg_priority change: takes effect in the same cycle. rr_ptr is preserved.

## Timing
- Reset values:
  - access_out=0, packet_out=0, grant_out=0, locked_out=0.
  - rr_ptr=NREQ-1, so requester 0 is first in round-robin.
  - wait_out = all ones while reset is high.
- Latency: a packet accepted in cycle N appears on access_out in cycle N+1.
- Throughput: 1 packet/cycle while wait_in is low.
- Full/stall: when access_out=1 and wait_in=1, all wait_out bits are high and the output is stable.
- Wait release: in the cycle wait_in falls, the held packet is consumed and a new winner may load in the same cycle, with no bubble.
- Simultaneous lock release and a new request: the release packet is accepted; the next cycle's round-robin search starts at owner+1.
- Reset mid-operation: the buffered packet is dropped, the lock is cleared, and rr_ptr is restored in the next cycle.

## Structure
- No shared package types. NREQ and PW are module parameters.
- The lock/ptr state and the output register stay in the top-level mtx_arbiter.
- One sub-module, mtx_rr_arbiter:
  - Combinational rotate-priority-rotate-back arbiter.
  - Inputs: request vector, pointer, priority-mode select.
  - Output: one-hot winner.
  - Parameterized by NREQ.

## Test plan
- Reset, round-robin, all three requesters continuously valid, wait_in=0 → grant_out sequence 001,010,100,001; access_out=1 every cycle from cycle 2.
- cfg_priority=1, requesters 1 and 2 valid → only requester 1 is accepted; wait_out[2]=1 throughout; requester 2 accepted after access_in[1] drops.
- wait_in held high 5 cycles with packet 0xA5 from requester 0 in the output stage → packet_out=0xA5 stable, wait_out=111 for 5 cycles; a new packet loads in the cycle wait_in falls.
- Requester 2 sends 3 packets, lock_in=1,1,0, while requesters 0 and 1 are valid → three consecutive grants to 2, locked_out=1 for 2 cycles, next grant to requester 0.
- tx_en=0 mid-stream → no new accepts, buffered packet delivered, then access_out=0; on tx_en=1, round-robin resumes from the saved rr_ptr.
- reset asserted with the lock held and access_out=1 → next cycle access_out=0, locked_out=0; first grant after reset goes to requester 0.
